// File: rtl/det_nxn_seq_pkg.sv
// det_pkg: shared constants, state type and permutation/parity tables for the
// sequential Leibniz determinant engine.
package det_pkg;

  localparam int MAX_N = 4;
  localparam int MAX_F = 24;

  typedef logic [MAX_F-1:0][MAX_N-1:0][1:0] perm_tab_t;
  typedef logic [MAX_F-1:0]                 par_vec_t;

  typedef enum logic [1:0] {LOAD, CALC, DONE} state_t;

  function automatic int fact(input int n);
    int r;
    r = 1;
    for (int unsigned i = 2; i <= unsigned'(n); i++) r = r * int'(i);
    return r;
  endfunction

  function automatic int log_fact(input int n);
    return $clog2(fact(n));
  endfunction

  // Rank p -> permutation via factorial-base digits: digit k selects the
  // k-th still-unused column, which yields lexicographic order.
  function automatic perm_tab_t gen_perm(input int n);
    perm_tab_t        t;
    logic [MAX_N-1:0] used;
    int unsigned      d, c;
    t = '0;
    for (int unsigned p = 0; p < unsigned'(fact(n)); p++) begin
      used = '0;
      for (int unsigned k = 0; k < unsigned'(n); k++) begin
        d = (p / unsigned'(fact(n - 1 - int'(k)))) % (unsigned'(n) - k);
        c = 0;
        for (int unsigned j = 0; j < unsigned'(n); j++) begin
          if (!used[2'(j)]) begin
            if (c == d) begin
              t[5'(p)][2'(k)] = 2'(j);
              used[2'(j)]     = 1'b1;
            end
            c++;
          end
        end
      end
    end
    return t;
  endfunction

  // The factorial-base digit sum equals the inversion count.
  function automatic par_vec_t gen_par(input int n);
    par_vec_t    v;
    int unsigned s;
    v = '0;
    for (int unsigned p = 0; p < unsigned'(fact(n)); p++) begin
      s = 0;
      for (int unsigned k = 0; k < unsigned'(n); k++)
        s += (p / unsigned'(fact(n - 1 - int'(k)))) % (unsigned'(n) - k);
      v[5'(p)] = s[0];
    end
    return v;
  endfunction

  localparam perm_tab_t PERM2 = gen_perm(2);
  localparam perm_tab_t PERM3 = gen_perm(3);
  localparam perm_tab_t PERM4 = gen_perm(4);
  localparam par_vec_t  PAR2  = gen_par(2);
  localparam par_vec_t  PAR3  = gen_par(3);
  localparam par_vec_t  PAR4  = gen_par(4);

endpackage

// File: rtl/det_nxn_seq_if.sv
// det_nxn_seq_if: element stream in, determinant out, both valid/ready.
// out_singular exists only when DET_SINGULAR_FLAG_EN is defined.
interface det_nxn_seq_if #(
  parameter int DW = 32,
  parameter int OW = 133
);
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [OW-1:0] out_det;
`ifdef DET_SINGULAR_FLAG_EN
  logic                 out_singular;

  modport master (output in_valid, in_data, out_ready,
                  input  in_ready, out_valid, out_det, out_singular);
  modport slave  (input  in_valid, in_data, out_ready,
                  output in_ready, out_valid, out_det, out_singular);
`else
  modport master (output in_valid, in_data, out_ready,
                  input  in_ready, out_valid, out_det);
  modport slave  (input  in_valid, in_data, out_ready,
                  output in_ready, out_valid, out_det);
`endif
endinterface

// File: rtl/det_nxn_seq_mac.sv
// det_mac: shared multiply/accumulate for one Leibniz term per N cycles.
// zero_nxt (DET_SINGULAR_FLAG_EN only) flags an all-zero next accumulator.
module det_mac #(
  parameter int OW = 133
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 en,
  input  logic                 first,
  input  logic                 last,
  input  logic                 negate,
  input  logic signed [OW-1:0] operand,
`ifdef DET_SINGULAR_FLAG_EN
  output logic                 zero_nxt,
`endif
  output logic signed [OW-1:0] acc
);
  logic signed [OW-1:0] prod, term, acc_nxt;

  // Truncation to OW is exact: every partial product fits by construction.
  always_comb begin
    term    = first ? operand : OW'(prod * operand);
    acc_nxt = negate ? acc - term : acc + term;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      prod <= '0;
      acc  <= '0;
    end else if (en) begin
      if (last) acc  <= acc_nxt;
      else      prod <= term;
    end
  end

`ifdef DET_SINGULAR_FLAG_EN
  assign zero_nxt = (acc_nxt == '0);
`endif
endmodule

// File: rtl/det_nxn_seq.sv
// det_nxn_seq: sequential N x N signed determinant (Leibniz, one shared MAC).
// Define DET_SINGULAR_FLAG_EN to add the registered out_singular flag.
module det_nxn_seq
  import det_pkg::*;
#(
  parameter int N  = 4,
  parameter int DW = 32
) (
  input logic          clk,
  input logic          rst_n,
  det_nxn_seq_if.slave bus
);
  localparam int         OW    = N * DW + log_fact(N);
  localparam int         NF    = fact(N);
  localparam logic [1:0] KLAST = 2'(N - 1);
  localparam logic [4:0] PLAST = 5'(NF - 1);
  localparam perm_tab_t  PERM  = (N == 2) ? PERM2 : (N == 3) ? PERM3 : PERM4;
  localparam par_vec_t   PAR   = (N == 2) ? PAR2  : (N == 3) ? PAR3  : PAR4;

  generate
    if (N < 2 || N > MAX_N) begin : g_bad_n
      $error("det_nxn_seq: N must be 2, 3 or 4");
    end
  endgenerate

  state_t               state, state_nxt;
  logic [1:0]           row, col, k;
  logic [4:0]           p;
  logic signed [DW-1:0] mat [MAX_N][MAX_N];
  logic                 beat, load_last, calc_en, calc_last;
  logic                 in_rdy, out_vld;
  logic signed [OW-1:0] operand, acc;

  always_comb begin
    state_nxt = state;
    in_rdy    = 1'b0;
    out_vld   = 1'b0;
    beat      = 1'b0;
    load_last = 1'b0;
    calc_en   = 1'b0;
    calc_last = 1'b0;
    case (state)
      LOAD: begin
        in_rdy    = rst_n;
        beat      = bus.in_valid && rst_n;
        load_last = beat && (row == KLAST) && (col == KLAST);
        if (load_last) state_nxt = CALC;
      end
      CALC: begin
        calc_en   = 1'b1;
        calc_last = (k == KLAST) && (p == PLAST);
        if (calc_last) state_nxt = DONE;
      end
      DONE: begin
        out_vld = 1'b1;
        if (bus.out_ready) state_nxt = LOAD;
      end
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= LOAD;
    else        state <= state_nxt;
  end

  // Element counter kept as row/col so no divide by N is needed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row <= '0;
      col <= '0;
      k   <= '0;
      p   <= '0;
    end else begin
      if (beat) begin
        if (col == KLAST) begin
          col <= '0;
          row <= (row == KLAST) ? '0 : row + 2'd1;
        end else begin
          col <= col + 2'd1;
        end
      end
      if (calc_en) begin
        if (k == KLAST) begin
          k <= '0;
          p <= (p == PLAST) ? '0 : p + 5'd1;
        end else begin
          k <= k + 2'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (beat) mat[row][col] <= bus.in_data;
  end

  assign operand = OW'(mat[k][PERM[p][k]]);

`ifdef DET_SINGULAR_FLAG_EN
  logic zero_nxt, sing;
`endif

  det_mac #(.OW(OW)) u_mac (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (load_last),
    .en      (calc_en),
    .first   (k == 2'd0),
    .last    (k == KLAST),
    .negate  (PAR[p]),
    .operand (operand),
`ifdef DET_SINGULAR_FLAG_EN
    .zero_nxt(zero_nxt),
`endif
    .acc     (acc)
  );

`ifdef DET_SINGULAR_FLAG_EN
  always_ff @(posedge clk) begin
    if (!rst_n)                       sing <= 1'b0;
    else if (calc_last)               sing <= zero_nxt;
    else if (out_vld && bus.out_ready) sing <= 1'b0;
  end
  assign bus.out_singular = sing;
`endif

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = out_vld;
  assign bus.out_det   = acc;
endmodule

// File: tb/tb_det_nxn_seq.sv
// tb_det_nxn_seq: directed and random matrices on N=4/3/2 instances, checked
// against a cofactor-expansion reference model.
module tb_det_nxn_seq;
  typedef logic signed [139:0] big_t;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  det_nxn_seq_if #(.DW(32), .OW(133)) if4 ();
  det_nxn_seq_if #(.DW(16), .OW(51))  if3 ();
  det_nxn_seq_if #(.DW(8),  .OW(17))  if2 ();

  det_nxn_seq #(.N(4), .DW(32)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
  det_nxn_seq #(.N(3), .DW(16)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave));
  det_nxn_seq #(.N(2), .DW(8))  dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));

  task automatic check(input string tag, input big_t obs, input big_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input int inst, input logic v, input big_t d);
    case (inst)
      0:       begin if4.in_valid = v; if4.in_data = 32'(d); end
      1:       begin if3.in_valid = v; if3.in_data = 16'(d); end
      default: begin if2.in_valid = v; if2.in_data = 8'(d);  end
    endcase
  endtask

  task automatic set_ordy(input int inst, input logic v);
    case (inst)
      0:       if4.out_ready = v;
      1:       if3.out_ready = v;
      default: if2.out_ready = v;
    endcase
  endtask

  function automatic logic rdy(input int inst);
    case (inst)
      0:       return if4.in_ready;
      1:       return if3.in_ready;
      default: return if2.in_ready;
    endcase
  endfunction

  function automatic logic vld(input int inst);
    case (inst)
      0:       return if4.out_valid;
      1:       return if3.out_valid;
      default: return if2.out_valid;
    endcase
  endfunction

  function automatic big_t det_of(input int inst);
    case (inst)
      0:       return big_t'(if4.out_det);
      1:       return big_t'(if3.out_det);
      default: return big_t'(if2.out_det);
    endcase
  endfunction

`ifdef DET_SINGULAR_FLAG_EN
  function automatic logic sng(input int inst);
    case (inst)
      0:       return if4.out_singular;
      1:       return if3.out_singular;
      default: return if2.out_singular;
    endcase
  endfunction
`endif

  function automatic big_t det3(input big_t x[9]);
    return x[0] * (x[4] * x[8] - x[5] * x[7])
         - x[1] * (x[3] * x[8] - x[5] * x[6])
         + x[2] * (x[3] * x[7] - x[4] * x[6]);
  endfunction

  // Row-major matrix with stride n; 4x4 by first-row cofactor expansion.
  function automatic big_t ref_det(input big_t m[16], input int n);
    big_t minor[9];
    big_t s;
    int   idx;
    s = 0;
    if (n == 2) return m[0] * m[3] - m[1] * m[2];
    if (n == 3) begin
      for (int i = 0; i < 9; i++) minor[i] = m[i];
      return det3(minor);
    end
    for (int c = 0; c < 4; c++) begin
      idx = 0;
      for (int r = 1; r < 4; r++)
        for (int j = 0; j < 4; j++)
          if (j != c) begin minor[idx] = m[r * 4 + j]; idx++; end
      s = s + ((c % 2 == 1) ? -m[c] : m[c]) * det3(minor);
    end
    return s;
  endfunction

  function automatic big_t rnd_elem(input int dw, input bit extreme);
    logic [31:0] r;
    big_t        lim;
    r   = $urandom;
    lim = big_t'(1) <<< (dw - 1);
    if (extreme) return r[0] ? lim - 1 : -lim;
    case (dw)
      32:      return big_t'($signed(r));
      16:      return big_t'($signed(r[15:0]));
      default: return big_t'($signed(r[7:0]));
    endcase
  endfunction

  task automatic run_case(input int inst, input int n, input big_t m[16], input big_t exp,
                          input bit gaps, input int hold, input string tag);
    int idx, budget, lat, exp_lat;
    bit got;
    idx     = 0;
    budget  = 0;
    exp_lat = (n == 4) ? 97 : (n == 3) ? 19 : 5;
    while (idx < n * n && budget < 500) begin
      @(negedge clk);
      budget++;
      if (gaps && $urandom_range(0, 2) == 0) begin
        drive(inst, 1'b0, big_t'($urandom));
      end else begin
        drive(inst, 1'b1, m[idx]);
        if (rdy(inst)) idx++;
      end
    end
    if (idx < n * n) check({tag, " load-timeout"}, big_t'(idx), big_t'(n * n));
    lat = 0;
    got = 1'b0;
    while (!got && lat < 300) begin
      @(negedge clk);
      lat++;
      drive(inst, 1'($urandom), big_t'($urandom));
      got = vld(inst);
    end
    check({tag, " latency"}, big_t'(lat), big_t'(exp_lat));
    check({tag, " det"}, det_of(inst), exp);
`ifdef DET_SINGULAR_FLAG_EN
    check({tag, " singular"}, big_t'(sng(inst)), big_t'(exp == 0));
`endif
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      drive(inst, 1'b1, big_t'($urandom));
      check({tag, " hold-valid"}, big_t'(vld(inst)), big_t'(1));
      check({tag, " hold-det"}, det_of(inst), exp);
      check({tag, " hold-in_ready"}, big_t'(rdy(inst)), big_t'(0));
    end
    if (hold > 0) begin
      @(negedge clk);
      drive(inst, 1'b0, '0);
      set_ordy(inst, 1'b1);
    end
    @(negedge clk);
    drive(inst, 1'b0, '0);
    check({tag, " valid-dropped"}, big_t'(vld(inst)), big_t'(0));
    check({tag, " in_ready-back"}, big_t'(rdy(inst)), big_t'(1));
`ifdef DET_SINGULAR_FLAG_EN
    check({tag, " singular-cleared"}, big_t'(sng(inst)), big_t'(0));
`endif
  endtask

  initial begin
    big_t m[16];
    big_t ident[16];
    ident = '{1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(i, 1'b0, '0);
      set_ordy(i, 1'b1);
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset in_ready[%0d]", i), big_t'(rdy(i)), big_t'(0));
      check($sformatf("reset out_valid[%0d]", i), big_t'(vld(i)), big_t'(0));
      check($sformatf("reset out_det[%0d]", i), det_of(i), big_t'(0));
    end
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++)
      check($sformatf("post-reset in_ready[%0d]", i), big_t'(rdy(i)), big_t'(1));

    run_case(0, 4, ident, big_t'(1), 1'b0, 0, "n4 identity");
    m = '{2, 0, 0, 0, 0, 3, 0, 0, 0, 0, -4, 0, 0, 0, 0, 5};
    run_case(0, 4, m, big_t'(-120), 1'b1, 0, "n4 diag");

    m = '{1, 2, 3, 4, 5, 6, 7, 8, 10, 0, 0, 0, 0, 0, 0, 0};
    run_case(1, 3, m, big_t'(-3), 1'b0, 0, "n3 base");
    m = '{4, 5, 6, 1, 2, 3, 7, 8, 10, 0, 0, 0, 0, 0, 0, 0};
    run_case(1, 3, m, big_t'(3), 1'b1, 0, "n3 swapped");
    m = '{1, 2, 3, 1, 2, 3, 4, 5, 6, 0, 0, 0, 0, 0, 0, 0};
    run_case(1, 3, m, big_t'(0), 1'b0, 0, "n3 equal-rows");

    m = '{-128, -128, 127, -128, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    run_case(2, 2, m, big_t'(32640), 1'b0, 0, "n2 extreme-a");
    m = '{-128, 127, -128, -128, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    run_case(2, 2, m, big_t'(32640), 1'b1, 0, "n2 extreme-b");

    for (int i = 0; i < 16; i++) m[i] = rnd_elem(32, 1'b0);
    set_ordy(0, 1'b0);
    run_case(0, 4, m, ref_det(m, 4), 1'b0, 10, "n4 hold");
    run_case(0, 4, ident, big_t'(1), 1'b0, 0, "n4 after-hold");

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drive(0, 1'b1, ident[i]);
    end
    @(negedge clk);
    drive(0, 1'b0, '0);
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midcalc reset in_ready", big_t'(rdy(0)), big_t'(0));
    check("midcalc reset out_valid", big_t'(vld(0)), big_t'(0));
    check("midcalc reset out_det", det_of(0), big_t'(0));
    rst_n = 1'b1;
    @(negedge clk);
    check("midcalc post-reset in_ready", big_t'(rdy(0)), big_t'(1));
    check("midcalc post-reset out_valid", big_t'(vld(0)), big_t'(0));
    run_case(0, 4, ident, big_t'(1), 1'b0, 0, "n4 identity-after-reset");

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 16; i++) m[i] = rnd_elem(32, r == 3);
      run_case(0, 4, m, ref_det(m, 4), r[0], 0, $sformatf("n4 random%0d", r));
      for (int i = 0; i < 16; i++) m[i] = (i < 9) ? rnd_elem(16, r == 3) : big_t'(0);
      run_case(1, 3, m, ref_det(m, 3), r[0], 0, $sformatf("n3 random%0d", r));
      for (int i = 0; i < 16; i++) m[i] = (i < 4) ? rnd_elem(8, r == 3) : big_t'(0);
      run_case(2, 2, m, ref_det(m, 2), r[0], 0, $sformatf("n2 random%0d", r));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
